// File: rtl/sync_pulse_arbiter.sv
// Shares one toggle/acknowledge pulse synchronizer among N requesters with round-robin grants.
// Define SYNC_ARB_OVERFLOW_FLAG_EN to add the sticky per-requester OVF output for dropped events.
module sync_pulse_arbiter #(
    parameter int N  = 4,
    parameter int TW = 2,
    parameter int CW = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [N-1:0]  REQ,
    input  logic          CHAN_RDY,
    output logic          CHAN_EN,
    output logic [TW-1:0] CHAN_TAG,
    output logic          BUSY,
    output logic [N-1:0]  DONE,
    output logic [N-1:0]  FULL
`ifdef SYNC_ARB_OVERFLOW_FLAG_EN
    ,
    output logic [N-1:0]  OVF
`endif
);

    typedef enum logic {stIdle, stBusy} arbState_t;

    localparam int SW = TW + 1;
    localparam logic [CW-1:0] CountMax = '1;

    arbState_t     state, stateNext;
    logic          armed;
    logic          grant, finish, anyPending;
    logic [TW-1:0] ptr, winner, ptrNext, searchIdx;
    logic [SW-1:0] searchSum;
    logic [N-1:0]  grantVec;
    logic [CW-1:0] count     [N];
    logic [CW-1:0] countNext [N];
`ifdef SYNC_ARB_OVERFLOW_FLAG_EN
    logic [N-1:0]  dropVec;
`endif

    assign BUSY = (state == stBusy);

    // First pending requester at or after the pointer, wrapping past N-1.
    always_comb begin
        winner     = '0;
        anyPending = 1'b0;
        searchSum  = '0;
        searchIdx  = '0;
        for (int k = 0; k < N; k++) begin
            searchSum = {1'b0, ptr} + SW'(k);
            if (searchSum >= SW'(N))
                searchSum = searchSum - SW'(N);
            searchIdx = searchSum[TW-1:0];
            if (!anyPending && count[searchIdx] != '0) begin
                anyPending = 1'b1;
                winner     = searchIdx;
            end
        end
    end

    assign ptrNext = (winner == TW'(N - 1)) ? '0 : winner + 1'b1;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            state <= stIdle;
        else
            state <= stateNext;
    end

    // The first BUSY cycle is skipped via 'armed' because the channel drops ready one cycle late.
    always_comb begin
        stateNext = state;
        grant     = 1'b0;
        finish    = 1'b0;
        case (state)
            stIdle: begin
                if (CHAN_RDY && anyPending) begin
                    grant     = 1'b1;
                    stateNext = stBusy;
                end
            end
            stBusy: begin
                if (armed && CHAN_RDY) begin
                    finish    = 1'b1;
                    stateNext = stIdle;
                end
            end
            default: stateNext = stIdle;
        endcase
    end

    // Saturated counters drop new events unless a grant consumes one in the same cycle.
    always_comb begin
        grantVec = '0;
`ifdef SYNC_ARB_OVERFLOW_FLAG_EN
        dropVec  = '0;
`endif
        for (int i = 0; i < N; i++) begin
            countNext[i] = count[i];
            grantVec[i]  = grant && (winner == TW'(i));
            if (REQ[i] && !grantVec[i]) begin
                if (count[i] != CountMax)
                    countNext[i] = count[i] + 1'b1;
            end else if (!REQ[i] && grantVec[i]) begin
                countNext[i] = count[i] - 1'b1;
            end
`ifdef SYNC_ARB_OVERFLOW_FLAG_EN
            dropVec[i] = REQ[i] && !grantVec[i] && (count[i] == CountMax);
`endif
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            CHAN_EN  <= 1'b0;
            CHAN_TAG <= '0;
            DONE     <= '0;
            FULL     <= '0;
            ptr      <= '0;
            armed    <= 1'b0;
            for (int i = 0; i < N; i++)
                count[i] <= '0;
        end else begin
            CHAN_EN <= grant;
            DONE    <= finish ? (N'(1) << CHAN_TAG) : '0;
            if (grant) begin
                CHAN_TAG <= winner;
                ptr      <= ptrNext;
                armed    <= 1'b0;
            end else if (state == stBusy) begin
                armed <= 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                count[i] <= countNext[i];
                FULL[i]  <= (countNext[i] == CountMax);
            end
        end
    end

`ifdef SYNC_ARB_OVERFLOW_FLAG_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            OVF <= '0;
        else
            OVF <= OVF | dropVec;
    end
`endif

endmodule

// File: tb/tb_sync_pulse_arbiter.sv
// Scoreboard bench for sync_pulse_arbiter: stimulus queues expected grant tags, a monitor checks
// every CHAN_EN and DONE pulse against them; a small channel model returns ready 4 cycles later.
module tb_sync_pulse_arbiter;

    localparam int N  = 4;
    localparam int TW = 2;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          resetN = 1'b0;
    logic [N-1:0]  req = '0;
    logic          chanRdy;
    logic          chanEn;
    logic [TW-1:0] chanTag;
    logic          busy;
    logic [N-1:0]  done;
    logic [N-1:0]  full;
`ifdef SYNC_ARB_OVERFLOW_FLAG_EN
    logic [N-1:0]  ovf;
`endif

    int checks = 0;
    int errors = 0;
    int expTag[$];
    int expDone[$];

    logic rdyModel = 1'b1;
    logic chanHold = 1'b0;
    int   rtCount  = 0;
    logic sawEn;

    assign chanRdy = rdyModel && !chanHold;

    sync_pulse_arbiter #(.N(N), .TW(TW), .CW(CW)) dut (
        .CLK      (clock),
        .RST      (resetN),
        .REQ      (req),
        .CHAN_RDY (chanRdy),
        .CHAN_EN  (chanEn),
        .CHAN_TAG (chanTag),
        .BUSY     (busy),
        .DONE     (done),
        .FULL     (full)
`ifdef SYNC_ARB_OVERFLOW_FLAG_EN
        ,
        .OVF      (ovf)
`endif
    );

    always #5 clock = ~clock;

    // Channel: ready drops once an enable is seen and comes back 4 cycles later.
    always @(posedge clock) begin
        #1;
        if (!resetN) begin
            rdyModel <= 1'b1;
            rtCount  <= 0;
        end else if (chanEn) begin
            rdyModel <= 1'b0;
            rtCount  <= 4;
        end else if (rtCount > 0) begin
            rtCount <= rtCount - 1;
            if (rtCount == 1)
                rdyModel <= 1'b1;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    // Monitor pops one expectation per grant and per completion pulse.
    always @(negedge clock) begin
        if (resetN) begin
            if (chanEn) begin
                if (expTag.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL grantUnexpected: actual tag=%0d required=no grant", chanTag);
                end else begin
                    checkOutput("grantTag", int'(chanTag), expTag.pop_front());
                    checkOutput("busyAtGrant", int'(busy), 1);
                end
            end
            if (done != '0) begin
                if (expDone.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL doneUnexpected: actual=%0d required=no done", done);
                end else begin
                    checkOutput("doneVec", int'(done), 1 << expDone.pop_front());
                    checkOutput("busyAtDone", int'(busy), 0);
                end
            end
        end
    end

    task automatic pushGrant(input int tag);
        expTag.push_back(tag);
        expDone.push_back(tag);
    endtask

    task automatic applyStimulus(input logic [N-1:0] vec, input int cycles);
        req = vec;
        repeat (cycles) @(negedge clock);
        req = '0;
    endtask

    task automatic applyReset();
        @(negedge clock);
        #2 resetN = 1'b0;
        expTag.delete();
        expDone.delete();
        repeat (2) @(negedge clock);
        #2 resetN = 1'b1;
        @(negedge clock);
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while ((expTag.size() != 0 || expDone.size() != 0 || busy) && n < budget) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("[TB] FAIL drainTimeout: actual pending grants=%0d dones=%0d required=0",
                     expTag.size(), expDone.size());
        end
        repeat (3) @(negedge clock);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;

        // Reset values while reset is held.
        repeat (2) @(negedge clock);
        checkOutput("rstEn",   int'(chanEn),  0);
        checkOutput("rstBusy", int'(busy),    0);
        checkOutput("rstTag",  int'(chanTag), 0);
        checkOutput("rstDone", int'(done),    0);
        checkOutput("rstFull", int'(full),    0);
        #2 resetN = 1'b1;
        @(negedge clock);

        // Single request: enable one cycle after the counted event.
        pushGrant(2);
        applyStimulus(4'b0100, 1);
        checkOutput("singleEnEarly", int'(chanEn), 0);
        @(negedge clock);
        checkOutput("singleEn",   int'(chanEn),  1);
        checkOutput("singleTag",  int'(chanTag), 2);
        checkOutput("singleBusy", int'(busy),    1);
        waitDrain(100);

        // Round-robin order and pointer wrap.
        applyReset();
        pushGrant(0); pushGrant(1); pushGrant(2); pushGrant(3);
        applyStimulus(4'b1111, 1);
        waitDrain(200);
        pushGrant(1); pushGrant(3);
        applyStimulus(4'b1010, 1);
        waitDrain(200);
        pushGrant(0);
        applyStimulus(4'b0001, 1);
        waitDrain(100);
        pushGrant(1); pushGrant(0);
        applyStimulus(4'b0011, 1);
        waitDrain(200);

        // Saturation: 20 events with the channel blocked leave exactly 15.
        applyReset();
        chanHold = 1'b1;
        applyStimulus(4'b0001, 20);
        checkOutput("satFull",  int'(full),   4'b0001);
        checkOutput("satNoEn",  int'(chanEn), 0);
        for (int i = 0; i < 15; i++)
            pushGrant(0);
        chanHold = 1'b0;
        waitDrain(400);
        checkOutput("satFullClear", int'(full), 0);

        // Event arriving on the grant edge for a count of 3 keeps the count at 3.
        applyReset();
        chanHold = 1'b1;
        applyStimulus(4'b0010, 3);
        for (int i = 0; i < 4; i++)
            pushGrant(1);
        req = 4'b0010;
        chanHold = 1'b0;
        @(negedge clock);
        req = '0;
        checkOutput("addRemEn", int'(chanEn), 1);
        waitDrain(200);

        // Ready stuck low blocks all grants until it rises.
        chanHold = 1'b1;
        pushGrant(2);
        applyStimulus(4'b0100, 1);
        sawEn = 1'b0;
        repeat (10) begin
            @(negedge clock);
            sawEn = sawEn | chanEn;
        end
        checkOutput("stuckNoEn", int'(sawEn), 0);
        chanHold = 1'b0;
        @(negedge clock);
        checkOutput("stuckReleaseEn",  int'(chanEn),  1);
        checkOutput("stuckReleaseTag", int'(chanTag), 2);
        waitDrain(100);

        // Reset in the middle of a transfer tagged 3, with more events pending.
        applyReset();
        pushGrant(3);
        applyStimulus(4'b1000, 1);
        n = 0;
        while (!chanEn && n < 10) begin
            @(negedge clock);
            n++;
        end
        checkOutput("midEnSeen", int'(chanEn),  1);
        checkOutput("midTag",    int'(chanTag), 3);
        applyStimulus(4'b1010, 2);
        #2 resetN = 1'b0;
        expTag.delete();
        expDone.delete();
        #1;
        checkOutput("midRstEn",   int'(chanEn),  0);
        checkOutput("midRstBusy", int'(busy),    0);
        checkOutput("midRstTag",  int'(chanTag), 0);
        checkOutput("midRstDone", int'(done),    0);
        checkOutput("midRstFull", int'(full),    0);
        repeat (2) @(negedge clock);
        #2 resetN = 1'b1;
        repeat (20) @(negedge clock);
        pushGrant(0); pushGrant(1); pushGrant(3);
        applyStimulus(4'b1011, 1);
        waitDrain(200);

`ifdef SYNC_ARB_OVERFLOW_FLAG_EN
        // Two dropped events on requester 2 set only its overflow bit.
        applyReset();
        checkOutput("ovfReset", int'(ovf), 0);
        chanHold = 1'b1;
        applyStimulus(4'b0100, 17);
        checkOutput("ovfSet",     int'(ovf),  4'b0100);
        checkOutput("ovfSetFull", int'(full), 4'b0100);
        applyReset();
        chanHold = 1'b0;
        checkOutput("ovfCleared", int'(ovf), 0);
`endif

        repeat (5) @(negedge clock);
        checkOutput("queuesEmpty", expTag.size() + expDone.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_pulse_arbiter.md
Name: sync_pulse_arbiter

Overview:
- Source-domain controller that shares one toggle/acknowledge pulse synchronizer channel among N requesters.
- Counts pending events per requester and grants the channel round-robin.
- Drives the channel enable and holds a stable requester tag for the full transfer; the tag is carried to the destination domain by a companion data register.
- Generates per-requester completion pulses when the channel's ready returns.

Parameters:
- N, 4, number of requesters (2..16).
- TW, 2, tag width; must satisfy 2**TW >= N.
- CW, 4, per-requester pending-event counter width; saturates at 2**CW-1.

Ports:
- CLK  input  1  source-domain clock; all state on posedge.
- RST  input  1  reset, asynchronous and active-low; clears all state.
- REQ  input  N  per-requester event strobe; each high cycle adds one pending event.
- CHAN_RDY  input  1  ready from the synchronizer channel.
- CHAN_EN  output  1  one-cycle enable to the synchronizer channel.
- CHAN_TAG  output  TW  index of the requester owning the current transfer.
- BUSY  output  1  high while a transfer is outstanding.
- DONE  output  N  one-hot one-cycle pulse when a transfer for that requester completes.
- FULL  output  N  per-requester counter at saturation.

Behaviour:
- Reset values: CHAN_EN=0, CHAN_TAG=0, BUSY=0, DONE=0, FULL=0, all counters 0, round-robin pointer 0, state IDLE.
- State machine has two states, IDLE and BUSY.
- IDLE transition: if CHAN_RDY=1 and any counter is nonzero, select the winner and assert CHAN_EN for exactly one cycle (registered output). In that same edge:
  - load CHAN_TAG with the winner index;
  - decrement the winner's counter;
  - set pointer = winner+1 mod N;
  - go to BUSY.
- Winner selection: first nonzero counter at or after the pointer, searching upward with wrap-around. Requester 0 wins ties immediately after reset.
- BUSY: CHAN_EN=0; CHAN_TAG and BUSY held. The channel drops ready in the cycle after enable, so BUSY ignores CHAN_RDY during the first cycle after entry.
- BUSY exit: from the second BUSY cycle onward, CHAN_RDY=1 causes return to IDLE, with DONE[CHAN_TAG] pulsing one cycle on that edge.
- Re-issue: IDLE may issue again on the cycle after DONE. Minimum spacing between CHAN_EN pulses is 3 cycles plus the channel round trip.
- No CHAN_EN is ever issued while BUSY=1 or while CHAN_RDY=0.
- Counter update per requester each edge: +1 if REQ[i], -1 if granted.
  - Simultaneous REQ and grant: count unchanged.
  - At saturation with REQ and no grant: event dropped, count stays 2**CW-1.
  - At saturation with REQ and grant: count unchanged, no loss.
- FULL[i] is the registered compare count==2**CW-1.
- Reset asserted mid-transfer: everything returns to reset values immediately (asynchronous). The channel shares this reset, so no stale acknowledge is expected.
- CHAN_TAG changes only on a grant edge.

Optional Feature:
- Macro: SYNC_ARB_OVERFLOW_FLAG_EN.
- When defined: adds output OVF [N-1:0]. OVF[i] is set sticky on any dropped event (REQ[i] while saturated and not granted) and cleared only by reset.
- When undefined: port absent and drops are silent; all other behaviour is identical.

Test Plan:
- Single request: N=4; REQ[2] one cycle with CHAN_RDY=1. Expected: CHAN_EN one cycle later with CHAN_TAG=2 and BUSY=1. After the model channel returns ready 4 cycles later, DONE=4'b0100 for one cycle and BUSY=0.
- Round-robin: REQ=4'b1111 for one cycle. Expected grant order 0,1,2,3. Then REQ[1] and REQ[3] together: next grants 1,3, and the pointer wraps correctly.
- Saturation (CW=4): REQ[0] held 20 cycles with CHAN_RDY=0. Expected: count=15 and FULL[0]=1. Releasing the channel yields exactly 15 grants to requester 0, then FULL[0]=0.
- Simultaneous add/remove: REQ[1] asserted on the grant edge for requester 1 with count=3. Expected: count stays 3, and no extra or missing grants.
- Ready stuck low: CHAN_RDY=0 with pending work. Expected: CHAN_EN never asserts. Raising CHAN_RDY produces a grant on the next edge.
- Mid-transfer reset: RST low during BUSY with CHAN_TAG=3. Expected: CHAN_EN, BUSY, DONE, FULL and counters all 0 immediately. After reset release, requester 0 has priority. With SYNC_ARB_OVERFLOW_FLAG_EN defined, OVF=0 and a forced drop sets only its bit.
